// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit unsigned subtractor with valid/ready handshakes on both sides.
// One bit-slice (two half-subtractor cells plus a registered borrow) is evaluated
// per clock, LSB first, so a result appears WIDTH edges after the operands are accepted.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             bq;

  // Bit-slice signals: cell 1 subtracts the operand bits, cell 2 the running borrow.
  logic a0;
  logic b0;
  logic d1;
  logic b1;
  logic s;
  logic b2;
  logic borrow_next;

  logic accept;
  logic last_bit;

  assign a0          = a_sh[0];
  assign b0          = b_sh[0];
  assign d1          = a0 ^ b0;
  assign b1          = ~a0 & b0;
  assign s           = d1 ^ bq;
  assign b2          = ~d1 & bq;
  assign borrow_next = b1 | b2;

  assign accept   = in_valid && (state == IDLE);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // The new difference bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_res_single
      assign res_next = s;
    end else begin : g_res_multi
      assign res_next = {s, res_sh[WIDTH-1:1]};
    end
  endgenerate

  // Handshake/status outputs decode directly from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: load in IDLE, count WIDTH slices in RUN, hold result until taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (last_bit) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand shifters, borrow flop, bit counter and the published result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      bq         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            cnt    <= '0;
            bq     <= 1'b0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          bq     <= borrow_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            diff       <= res_next;
            borrow_out <= borrow_next;
          end
        end
        default: begin
          // DONE: diff/borrow_out hold until the next completion overwrites them.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random checks of serial_subtractor_ctrl at WIDTH=8, plus a WIDTH=1 build.
module tb_serial_subtractor_ctrl;

  logic       clk;
  logic       rst_n;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       borrow_out;
  logic       busy;

  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       out_valid1;
  logic       out_ready1;
  logic [0:0] diff1;
  logic       borrow_out1;
  logic       busy1;

  int n_checks;
  int n_fail;

  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .a          (a1),
    .b          (b1),
    .out_valid  (out_valid1),
    .out_ready  (out_ready1),
    .diff       (diff1),
    .borrow_out (borrow_out1),
    .busy       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until out_valid is seen, bounded so a stuck DUT cannot hang the run.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // One full transaction with out_ready held high.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb, input string tag);
    int lat;
    lat = 0;
    while (!in_ready && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    wait_valid(lat);
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " diff"}, 32'(diff), 32'(ed));
    check({tag, " borrow"}, 32'(borrow_out), 32'(eb));
    tick();
    check({tag, " idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    $display("op %s: a=%0d b=%0d diff=%0d borrow=%0d", tag, av, bv, diff, borrow_out);
  endtask

  initial begin
    int lat;
    int seen;
    logic [8:0] ref_sum;
    logic [7:0] ra;
    logic [7:0] rb;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    in_valid1 = 1'b0;
    a1        = '0;
    b1        = '0;
    out_ready1 = 1'b1;

    tick();
    tick();
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset borrow", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors with hand-computed results.
    run_op(8'd200, 8'd55, 8'd145, 1'b0, "200-55");
    run_op(8'd5,   8'd9,  8'hFC,  1'b1, "5-9");
    run_op(8'h00,  8'hFF, 8'h01,  1'b1, "00-FF");
    run_op(8'h3C,  8'h3C, 8'h00,  1'b0, "3C-3C");
    run_op(8'hFF,  8'h00, 8'hFF,  1'b0, "FF-00");

    // Backpressure: result held five cycles while a new pair waits with in_valid high.
    out_ready = 1'b0;
    a = 8'd200;
    b = 8'd55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'd8);
    a = 8'd10;
    b = 8'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp diff", 32'(diff), 32'd145);
      check("bp in_ready", 32'(in_ready), 32'd0);
    end
    $display("op backpressure hold: diff=%0d held 5 cycles", diff);
    out_ready = 1'b1;
    tick();
    check("bp back to idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp second accepted", 32'(busy), 32'd1);
    wait_valid(lat);
    check("bp 10-3 latency", 32'(lat), 32'd8);
    check("bp 10-3 diff", 32'(diff), 32'd7);
    check("bp 10-3 borrow", 32'(borrow_out), 32'd0);
    $display("op 10-3 after backpressure: diff=%0d", diff);
    tick();

    // Reset asserted just before the 4th RUN edge of 200-55 and held across it.
    a = 8'd200;
    b = 8'd55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst diff", 32'(diff), 32'd0);
    check("midrst borrow", 32'(borrow_out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midrst no result", 32'(seen), 32'd0);
    $display("op reset mid-run: aborted, out_valid seen %0d times", seen);
    run_op(8'd9, 8'd4, 8'd5, 1'b0, "9-4");

    // WIDTH=1 build: result one edge after accept.
    a1 = 1'b0;
    b1 = 1'b1;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("w1 not yet valid", 32'(out_valid1), 32'd0);
    tick();
    check("w1 out_valid", 32'(out_valid1), 32'd1);
    check("w1 diff", 32'(diff1), 32'd1);
    check("w1 borrow", 32'(borrow_out1), 32'd1);
    $display("op w1 0-1: diff=%0d borrow=%0d", diff1, borrow_out1);
    tick();
    check("w1 idle", 32'(in_ready1), 32'd1);

    // Random sweep against a 9-bit reference subtraction.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ref_sum = {1'b0, ra} - {1'b0, rb};
      run_op(ra, rb, ref_sum[7:0], ref_sum[8], "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial WIDTH-bit subtractor controller built around the team's half-subtractor cell. It accepts an operand pair over a valid/ready handshake and steps the pair LSB-first through one bit-slice per clock. Each slice is two half-subtractor cells plus a registered borrow. The block returns diff = a - b (mod 2^WIDTH) and a final borrow over a second valid/ready handshake. It is the area-minimal subtract resource for multi-bit datapaths that tolerate WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair a/b is presented
in_ready  output  1  block can accept an operand pair
a  input  WIDTH  minuend, sampled on the accept edge
b  input  WIDTH  subtrahend, sampled on the accept edge
out_valid  output  1  diff/borrow_out hold a valid result
out_ready  input  1  consumer takes the result
diff  output  WIDTH  (a - b) mod 2^WIDTH
borrow_out  output  1  1 when a < b (unsigned)
busy  output  1  1 in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, diff=0, borrow_out=0. Internal shift registers, bit counter and borrow flop reset to 0.
- State machine has three states:
  - IDLE: in_ready=1. On in_valid&&in_ready: load a_sh<=a, b_sh<=b, clear borrow flop bq<=0 and bit counter cnt<=0, go to RUN.
  - RUN: in_ready=0. Every edge processes bit 0 of a_sh/b_sh:
    - cell 1: d1=a0^b0, b1=~a0&b1_in(b0)
    - cell 2: s=d1^bq, b2=~d1&bq
    - next borrow = b1|b2
    - s shifts into the MSB of the result register, which shifts right; a_sh/b_sh shift right; bq<=next borrow; cnt++.
    - After the WIDTH-th RUN edge (cnt==WIDTH-1 at that edge): diff<=completed result, borrow_out<=final next borrow, go to DONE.
  - DONE: out_valid=1. diff and borrow_out are held stable while out_ready=0. On out_ready=1: go to IDLE and drop out_valid on that edge.
- Latency: out_valid rises exactly WIDTH edges after the accept edge. Minimum op-to-op spacing is WIDTH+2 cycles (in_ready is high only in IDLE; there is no accept in DONE).
- Counter width is clog2(WIDTH+1). WIDTH=1 gives a single RUN cycle.
- in_valid, a and b are ignored outside IDLE. A pending in_valid during RUN/DONE must stay asserted by the producer (standard valid/ready: no drop is implied).
- out_ready outside DONE has no effect.
- diff/borrow_out keep the last result after leaving DONE until the next completion overwrites them. Consumers qualify them with out_valid only.
- Reset mid-operation (RUN or DONE) aborts immediately: all outputs go to reset values and no result is emitted after reset deasserts.
- Arithmetic is unsigned; borrow_out equals the carry-out inverse of a + ~b + 1.

Test Plan:
- WIDTH=8, a=200, b=55, out_ready=1 -> out_valid 8 edges after accept, diff=145, borrow_out=0, then back to IDLE with in_ready=1.
- a=5, b=9 -> diff=252 (0xFC), borrow_out=1. Also a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
- a=b=0x3C -> diff=0x00, borrow_out=0. Also a=0xFF, b=0x00 -> diff=0xFF, borrow_out=0.
- Backpressure: complete 200-55 with out_ready=0 for 5 cycles -> out_valid, diff=145 and in_ready=0 held all 5 cycles. The pair 10-3 presented with in_valid=1 during this window is accepted only after IDLE is re-entered and yields diff=7.
- Reset mid-op: pulse rst_n low for 1 cycle at the 4th RUN edge of 200-55 -> outputs return to reset values asynchronously, no out_valid ever appears for that op, next op 9-4 yields diff=5.
- WIDTH=1 build: a=0, b=1 -> diff=1, borrow_out=1 one edge after accept. Also run a random sweep of 1000 pairs at WIDTH=8 against a reference model.
